// File: rtl/l1_to_axi_burst_if.sv
// rtl/l1_to_axi_burst_if.sv - AXI4 read/write bus bundle between the L1 burst bridge and the interconnect
interface l1_to_axi_burst_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int AXI_ID_W   = 6
);
    logic [ADDR_WIDTH-1:0]   araddr;
    logic [7:0]              arlen;
    logic [1:0]              arburst;
    logic [2:0]              arsize;
    logic [AXI_ID_W-1:0]     arid;
    logic [3:0]              arcache;
    logic                    arvalid;
    logic                    arready;

    logic [DATA_WIDTH-1:0]   rdata;
    logic [AXI_ID_W-1:0]     rid;
    logic                    rvalid;
    logic                    rready;

    logic [ADDR_WIDTH-1:0]   awaddr;
    logic [7:0]              awlen;
    logic [1:0]              awburst;
    logic [2:0]              awsize;
    logic [AXI_ID_W-1:0]     awid;
    logic [3:0]              awcache;
    logic                    awvalid;
    logic                    awready;

    logic [DATA_WIDTH-1:0]   wdata;
    logic [DATA_WIDTH/8-1:0] wstrb;
    logic                    wlast;
    logic                    wvalid;
    logic                    wready;

    logic                    bvalid;
    logic                    bready;

    modport master (
        output araddr, arlen, arburst, arsize, arid, arcache, arvalid,
        input  arready,
        input  rdata, rid, rvalid,
        output rready,
        output awaddr, awlen, awburst, awsize, awid, awcache, awvalid,
        input  awready,
        output wdata, wstrb, wlast, wvalid,
        input  wready,
        input  bvalid,
        output bready
    );

    modport slave (
        input  araddr, arlen, arburst, arsize, arid, arcache, arvalid,
        output arready,
        output rdata, rid, rvalid,
        input  rready,
        input  awaddr, awlen, awburst, awsize, awid, awcache, awvalid,
        output awready,
        input  wdata, wstrb, wlast, wvalid,
        output wready,
        output bvalid,
        input  bready
    );
endinterface

// File: rtl/l1_to_axi_burst.sv
// rtl/l1_to_axi_burst.sv - L1 requester to AXI4 bridge issuing in-order read and write bursts
module l1_to_axi_burst #(
    parameter int DATA_WIDTH       = 32,
    parameter int ADDR_WIDTH       = 32,
    parameter int SUB_ID_W         = 2,
    parameter int AXI_ID_W         = 6,
    parameter int REQ_DEPTH        = 16,
    parameter int DATA_DEPTH       = 16,
    parameter int MAX_BURST        = 16,
    parameter int MAX_WR_IN_FLIGHT = 64,
    parameter int DCACHE_ID        = 1
) (
    input  logic                                         clk,
    input  logic                                         rst,
    input  logic                                         req_push,
    input  logic [ADDR_WIDTH-$clog2(DATA_WIDTH/8)-1:0]   req_addr,
    input  logic [DATA_WIDTH/8-1:0]                      req_be,
    input  logic                                         req_rnw,
    input  logic [4:0]                                   req_len,
    input  logic [SUB_ID_W-1:0]                          req_sub_id,
    output logic                                         req_full,
    input  logic                                         wr_data_push,
    input  logic [DATA_WIDTH-1:0]                        wr_data,
    output logic                                         data_full,
    output logic [DATA_WIDTH-1:0]                        rd_data,
    output logic                                         rd_data_valid,
    output logic [SUB_ID_W-1:0]                          rd_sub_id,
    output logic                                         wr_in_flight,
    l1_to_axi_burst_if.master                            axi
);
    localparam int W  = $clog2(DATA_WIDTH/8);
    localparam int WA = ADDR_WIDTH - W;
    localparam int BE = DATA_WIDTH/8;
    localparam int RP = $clog2(REQ_DEPTH);
    localparam int DP = $clog2(DATA_DEPTH);
    localparam int CW = $clog2(MAX_WR_IN_FLIGHT+1);
    localparam logic [CW-1:0] WR_MAX = CW'(MAX_WR_IN_FLIGHT);
    localparam logic [1:0]    DC_ID  = 2'(DCACHE_ID);

    typedef struct packed {
        logic [WA-1:0]       addr;
        logic [BE-1:0]       be;
        logic                rnw;
        logic [4:0]          len;
        logic [SUB_ID_W-1:0] sub_id;
    } req_t;

    typedef enum logic {S_IDLE, S_ACTIVE} wr_state_e;

    // request FIFO (first-word fall-through)
    req_t            req_mem_q [REQ_DEPTH];
    logic [RP-1:0]   req_wp_q, req_wp_d, req_rp_q, req_rp_d, req_rp_nxt;
    logic [RP:0]     req_cnt_q, req_cnt_d;
    req_t            head;
    logic            head_valid, next_valid, next_rnw, req_pop;

    // write-data FIFO
    logic [DATA_WIDTH-1:0] dat_mem_q [DATA_DEPTH];
    logic [DP-1:0]   dat_wp_q, dat_wp_d, dat_rp_q, dat_rp_d;
    logic [DP:0]     dat_cnt_q, dat_cnt_d;
    logic            dat_valid, dat_pop;

    wr_state_e       state_q, state_d;
    logic            aw_done_q, aw_done_d, w_done_q, w_done_d;
    logic [4:0]      beat_q, beat_d;
    logic [CW-1:0]   wr_cnt_q, wr_cnt_d;

    logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
    logic [SUB_ID_W-1:0]   rd_sub_id_q, rd_sub_id_d;
    logic                  rd_valid_q, rd_valid_d;

    logic [1:0]      sub_lo;
    logic [5:0]      len_p1;
    logic [2:0]      align_lg;
    logic [WA-1:0]   ar_word;
    logic            ar_valid, rd_pop;
    logic            aw_valid, w_valid, w_last;
    logic            aw_hs, w_hs, last_hs, wr_finish;
    logic            head_is_wr, next_is_wr;
    logic [AXI_ID_W-1:0] unused_rid;

    assign head       = req_mem_q[req_rp_q];
    assign head_valid = (req_cnt_q != '0);
    assign req_rp_nxt = req_rp_q + 1'b1;
    assign next_rnw   = req_mem_q[req_rp_nxt].rnw;
    assign next_valid = (req_cnt_q > (RP+1)'(1));
    assign req_full   = (req_cnt_q == (RP+1)'(REQ_DEPTH));

    assign dat_valid  = (dat_cnt_q != '0);
    assign data_full  = (dat_cnt_q == (DP+1)'(DATA_DEPTH));

    // Read path: D-cache reads must not overtake writes still awaiting B.
    assign sub_lo   = 2'(head.sub_id);
    assign ar_valid = head_valid & head.rnw & ~((sub_lo == DC_ID) & (wr_cnt_q != '0));
    assign rd_pop   = ar_valid & axi.arready;

    always_comb begin
        len_p1   = {1'b0, head.len} + 6'd1;
        align_lg = '0;
        for (int i = 0; i < 6; i++) begin
            if (len_p1[i]) align_lg = 3'(i);
        end
        ar_word  = head.addr & ~((WA'(1) << align_lg) - WA'(1));
    end

    assign axi.arvalid = ar_valid;
    assign axi.araddr  = {ar_word, {W{1'b0}}};
    assign axi.arlen   = {3'b000, head.len};
    assign axi.arburst = (head.len != 5'd0) ? 2'b01 : 2'b00;
    assign axi.arsize  = 3'(W);
    assign axi.arid    = AXI_ID_W'(head.sub_id);
    assign axi.arcache = 4'b0010;
    assign axi.rready  = 1'b1;

    // Write path handshakes
    assign head_is_wr = head_valid & ~head.rnw;
    assign next_is_wr = next_valid & ~next_rnw;
    assign w_last     = (beat_q == head.len);

    always_comb begin
        aw_valid = 1'b0;
        w_valid  = 1'b0;
        if (state_q == S_ACTIVE) begin
            aw_valid = ~aw_done_q;
            w_valid  = dat_valid & ~w_done_q;
        end
    end

    assign aw_hs     = aw_valid & axi.awready;
    assign w_hs      = w_valid & axi.wready;
    assign last_hs   = w_hs & w_last;
    assign wr_finish = (state_q == S_ACTIVE) & (aw_done_q | aw_hs) & (w_done_q | last_hs);
    assign req_pop   = rd_pop | wr_finish;
    assign dat_pop   = w_hs;

    assign axi.awvalid = aw_valid;
    assign axi.awaddr  = {head.addr, {W{1'b0}}};
    assign axi.awlen   = {3'b000, head.len};
    assign axi.awburst = 2'b01;
    assign axi.awsize  = 3'(W);
    assign axi.awid    = AXI_ID_W'(head.sub_id);
    assign axi.awcache = 4'b0010;
    assign axi.wvalid  = w_valid;
    assign axi.wdata   = dat_mem_q[dat_rp_q];
    assign axi.wstrb   = head.be;
    assign axi.wlast   = w_last;
    assign axi.bready  = 1'b1;

    always_comb begin
        wr_cnt_d = wr_cnt_q;
        case ({wr_finish, axi.bvalid})
            2'b10:   wr_cnt_d = wr_cnt_q + CW'(1);
            2'b01:   wr_cnt_d = wr_cnt_q - CW'(1);
            default: wr_cnt_d = wr_cnt_q;
        endcase
    end
    assign wr_in_flight = (wr_cnt_q != '0);

    // Finishing a burst can chain straight into the next write head.
    always_comb begin
        state_d   = state_q;
        aw_done_d = aw_done_q;
        w_done_d  = w_done_q;
        beat_d    = beat_q;
        case (state_q)
            S_IDLE: begin
                if (head_is_wr && (wr_cnt_q < WR_MAX)) state_d = S_ACTIVE;
            end
            S_ACTIVE: begin
                if (aw_hs)   aw_done_d = 1'b1;
                if (w_hs)    beat_d    = beat_q + 5'd1;
                if (last_hs) w_done_d  = 1'b1;
                if (wr_finish) begin
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    beat_d    = '0;
                    state_d   = (next_is_wr && (wr_cnt_d < WR_MAX)) ? S_ACTIVE : S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        req_wp_d  = req_wp_q + RP'(req_push);
        req_rp_d  = req_rp_q + RP'(req_pop);
        req_cnt_d = req_cnt_q + (RP+1)'(req_push) - (RP+1)'(req_pop);
        dat_wp_d  = dat_wp_q + DP'(wr_data_push);
        dat_rp_d  = dat_rp_q + DP'(dat_pop);
        dat_cnt_d = dat_cnt_q + (DP+1)'(wr_data_push) - (DP+1)'(dat_pop);
    end

    always_comb begin
        rd_data_d   = axi.rdata;
        rd_sub_id_d = axi.rid[SUB_ID_W-1:0];
        rd_valid_d  = axi.rvalid;
    end
    assign unused_rid = axi.rid;

    always_ff @(posedge clk) begin
        if (rst) begin
            req_wp_q   <= '0;
            req_rp_q   <= '0;
            req_cnt_q  <= '0;
            dat_wp_q   <= '0;
            dat_rp_q   <= '0;
            dat_cnt_q  <= '0;
            state_q    <= S_IDLE;
            aw_done_q  <= 1'b0;
            w_done_q   <= 1'b0;
            beat_q     <= '0;
            wr_cnt_q   <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            req_wp_q   <= req_wp_d;
            req_rp_q   <= req_rp_d;
            req_cnt_q  <= req_cnt_d;
            dat_wp_q   <= dat_wp_d;
            dat_rp_q   <= dat_rp_d;
            dat_cnt_q  <= dat_cnt_d;
            state_q    <= state_d;
            aw_done_q  <= aw_done_d;
            w_done_q   <= w_done_d;
            beat_q     <= beat_d;
            wr_cnt_q   <= wr_cnt_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    always_ff @(posedge clk) begin
        rd_data_q   <= rd_data_d;
        rd_sub_id_q <= rd_sub_id_d;
        if (req_push)     req_mem_q[req_wp_q] <= '{req_addr, req_be, req_rnw, req_len, req_sub_id};
        if (wr_data_push) dat_mem_q[dat_wp_q] <= wr_data;
    end

    assign rd_data       = rd_data_q;
    assign rd_sub_id     = rd_sub_id_q;
    assign rd_data_valid = rd_valid_q;

    a_req_overflow:  assert property (@(posedge clk) disable iff (rst) !(req_push && req_full));
    a_data_overflow: assert property (@(posedge clk) disable iff (rst) !(wr_data_push && data_full));
    a_b_underflow:   assert property (@(posedge clk) disable iff (rst) !(axi.bvalid && (wr_cnt_q == '0)));
    a_wr_cnt_max:    assert property (@(posedge clk) disable iff (rst) wr_cnt_q <= WR_MAX);
    a_burst_len:     assert property (@(posedge clk) disable iff (rst)
                                      head_valid |-> (len_p1 <= 6'(MAX_BURST)));
endmodule
